// File: rtl/neuron_train_sequencer.sv
// Epoch sequencer for perceptron training: streams samples from a synchronous memory into
// the neuron over a request/ready handshake and stops on weight convergence or an epoch limit.
module neuron_train_sequencer #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_EPOCH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] nSamples,
  output logic              memRd,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [15:0]       memData,
  input  logic              requestFlag,
  output logic              dataReady,
  output logic [6:0]        x1,
  output logic [6:0]        x2,
  output logic [1:0]        t,
  output logic [31:0]       nOut,
  input  logic [13:0]       w1,
  input  logic [13:0]       w2,
  input  logic [13:0]       b,
  output logic              busy,
  output logic              finished,
  output logic              converged,
  output logic [7:0]        epochCount
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StWaitMem, StWaitReq, StCheck, StPresent, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        epoch_q, epoch_d;
  logic              conv_q, conv_d;
  logic              pend_q, pend_d;
  logic              req_prev_q, req_prev_d;
  logic [41:0]       snap_q, snap_d;
  logic [15:0]       sample_q, sample_d;
  logic              fin_q;
  logic [41:0]       weights;
  logic              req_rise;

  assign weights  = {w1, w2, b};
  assign req_rise = requestFlag & ~req_prev_q;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    epoch_d    = epoch_q;
    conv_d     = conv_q;
    pend_d     = pend_q;
    req_prev_d = requestFlag;
    snap_d     = snap_q;
    sample_d   = sample_q;
    memRd      = 1'b0;
    dataReady  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Edge history restarts with each run so a request held across start still counts.
        req_prev_d = start ? 1'b0 : req_prev_q;
        if (start) begin
          n_d     = nSamples;
          idx_d   = '0;
          epoch_d = '0;
          conv_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = (nSamples == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        memRd   = 1'b1;
        state_d = StWaitMem;
      end
      StWaitMem: begin
        sample_d = memData;
        state_d  = StWaitReq;
      end
      StWaitReq: begin
        if (pend_q) state_d = (idx_q == '0) ? StCheck : StPresent;
      end
      StCheck: begin
        if (epoch_q != 8'd0 && weights == snap_q) begin
          conv_d  = 1'b1;
          state_d = StDone;
        end else if (epoch_q == 8'(MAX_EPOCH)) begin
          state_d = StDone;
        end else begin
          snap_d  = weights;
          state_d = StPresent;
        end
      end
      StPresent: begin
        dataReady = 1'b1;
        pend_d    = 1'b0;
        if (idx_q == n_q - ADDR_W'(1)) begin
          idx_d = '0;
          if (epoch_q != 8'hff) epoch_d = epoch_q + 8'd1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
        state_d = StFetch;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && req_rise) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      n_q        <= '0;
      idx_q      <= '0;
      epoch_q    <= '0;
      conv_q     <= 1'b0;
      pend_q     <= 1'b0;
      req_prev_q <= 1'b0;
      snap_q     <= '0;
      sample_q   <= '0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      epoch_q    <= epoch_d;
      conv_q     <= conv_d;
      pend_q     <= pend_d;
      req_prev_q <= req_prev_d;
      snap_q     <= snap_d;
      sample_q   <= sample_d;
      fin_q      <= (state_q == StDone);
    end
  end

  assign memAddr    = (state_q == StFetch) ? idx_q : '0;
  assign x1         = sample_q[6:0];
  assign x2         = sample_q[13:7];
  assign t          = sample_q[15:14];
  assign nOut       = 32'(n_q);
  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign finished   = fin_q;
  assign converged  = conv_q;
  assign epochCount = epoch_q;

endmodule

// File: tb/tb_neuron_train_sequencer.sv
// Bench for neuron_train_sequencer: table of training runs, randomized runs against an
// epoch-level reference model, and hand sequences for latency, ignored start, n=0 and reset.
module tb_neuron_train_sequencer;

  localparam int ADDR_W = 8;
  localparam int MAXE   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] nSamples = '0;
  logic              memRd;
  logic [ADDR_W-1:0] memAddr;
  logic [15:0]       memData = '0;
  logic              requestFlag = 1'b0;
  logic              dataReady;
  logic [6:0]        x1, x2;
  logic [1:0]        t;
  logic [31:0]       nOut;
  logic [13:0]       w1, w2, b;
  logic              busy, finished, converged;
  logic [7:0]        epochCount;

  neuron_train_sequencer #(.ADDR_W(ADDR_W), .MAX_EPOCH(MAXE)) dut (
    .clk(clk), .rst(rst), .start(start), .nSamples(nSamples), .memRd(memRd),
    .memAddr(memAddr), .memData(memData), .requestFlag(requestFlag), .dataReady(dataReady),
    .x1(x1), .x2(x2), .t(t), .nOut(nOut), .w1(w1), .w2(w2), .b(b), .busy(busy),
    .finished(finished), .converged(converged), .epochCount(epochCount)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  always @(posedge clk) if (memRd) memData <= mem[memAddr];

  int memrd_cnt = 0;
  int dr_cnt = 0;
  always @(negedge clk) begin
    if (memRd) memrd_cnt++;
    if (dataReady) dr_cnt++;
  end

  // Neuron weight model: weights move after every presented sample until `freeze` samples.
  int pulses_k = 0;
  int freeze = 0;
  function automatic logic [41:0] wvec(input int k, input int f);
    int m;
    m = (k < f) ? k : f;
    return {14'(m + 1), 14'(m * 3 + 5), 14'(m * 7 + 2)};
  endfunction
  assign {w1, w2, b} = wvec(pulses_k, freeze);

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Epoch-level model: the weights seen at the start of each epoch decide the outcome.
  task automatic model(input int n, input int f, output int pulses, output bit conv,
                       output int ep);
    logic [41:0] prev, cur;
    prev = '0;
    conv = 0;
    ep = 0;
    if (n == 0) begin
      pulses = 0;
      return;
    end
    for (int e = 0; e <= MAXE; e++) begin
      cur = wvec(e * n, f);
      if (e >= 1 && cur == prev) begin
        conv = 1; ep = e; break;
      end
      if (e == MAXE) begin
        ep = e; break;
      end
      prev = cur;
    end
    pulses = ep * n;
  endtask

  task automatic run_case(input int n, input int f, input int dly, input int exp_p,
                          input bit exp_c, input int exp_e);
    int k, cd;
    bit done;
    k = 0;
    done = 0;
    freeze = f;
    pulses_k = 0;
    @(negedge clk);
    nSamples = ADDR_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run_nout", 64'(nOut), 64'(n));
    chk("run_busy", 64'(busy), 64'(n != 0));
    cd = $urandom_range(0, dly);
    for (int c = 0; c < 3000 && !done; c++) begin
      if (finished) begin
        done = 1;
        chk("run_pulses", 64'(k), 64'(exp_p));
        chk("run_conv", 64'(converged), 64'(exp_c));
        chk("run_epoch", 64'(epochCount), 64'(exp_e));
      end else begin
        if (dataReady) begin
          chk("run_sample", 64'({t, x2, x1}), 64'(mem[(n == 0) ? 0 : k % n]));
          k++;
          pulses_k = k;
          requestFlag = 1'b0;
          cd = $urandom_range(0, dly);
        end else if (!requestFlag) begin
          if (cd == 0) requestFlag = 1'b1;
          else cd--;
        end
        @(negedge clk);
      end
    end
    if (!done) chk("run_timeout", 64'd0, 64'd1);
    requestFlag = 1'b0;
  endtask

  typedef struct {
    int n;
    int f;
    int dly;
    int exp_p;
    bit exp_c;
    int exp_e;
  } vec_t;

  vec_t vecs [7];
  int m0, d0;

  initial begin
    vecs[0] = '{n: 3, f: 6,    dly: 1, exp_p: 9,  exp_c: 1, exp_e: 3};
    vecs[1] = '{n: 2, f: 1000, dly: 0, exp_p: 8,  exp_c: 0, exp_e: 4};
    vecs[2] = '{n: 1, f: 0,    dly: 2, exp_p: 1,  exp_c: 1, exp_e: 1};
    vecs[3] = '{n: 4, f: 5,    dly: 0, exp_p: 12, exp_c: 1, exp_e: 3};
    vecs[4] = '{n: 5, f: 15,   dly: 3, exp_p: 20, exp_c: 1, exp_e: 4};
    vecs[5] = '{n: 5, f: 16,   dly: 1, exp_p: 20, exp_c: 0, exp_e: 4};
    vecs[6] = '{n: 0, f: 0,    dly: 0, exp_p: 0,  exp_c: 0, exp_e: 0};
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    @(negedge clk);
    chk("reset_outputs", 64'({memRd, memAddr, dataReady, x1, x2, t, busy, finished, converged,
                              epochCount}), 64'd0);
    chk("reset_nout", 64'(nOut), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Latency, request during FETCH of sample 1, start while busy, then mid-epoch reset.
    freeze = 100;
    pulses_k = 0;
    @(negedge clk);
    nSamples = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lat_memrd", 64'({memRd, memAddr}), 64'({1'b1, 8'd0}));
    requestFlag = 1'b1;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      chk("lat_first_ready", 64'(dataReady), 64'(c == 5));
    end
    chk("lat_sample0", 64'({t, x2, x1}), 64'(mem[0]));
    requestFlag = 1'b0;
    pulses_k = 1;
    @(negedge clk);
    chk("fetch1", 64'({memRd, memAddr}), 64'({1'b1, 8'd1}));
    requestFlag = 1'b1;
    nSamples = 8'd7;
    start = 1'b1;
    for (int c = 7; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("ignored_start_nout", 64'(nOut), 64'd3);
      chk("s1_ready", 64'(dataReady), 64'(c == 9));
    end
    chk("s1_sample", 64'({t, x2, x1}), 64'(mem[1]));
    requestFlag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_outputs", 64'({memRd, memAddr, dataReady, x1, x2, t, busy, finished,
                                 converged, epochCount}), 64'd0);
    chk("midreset_nout", 64'(nOut), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // nSamples == 0: finished at cycle 2, no memory read, no presentation.
    m0 = memrd_cnt;
    d0 = dr_cnt;
    @(negedge clk);
    nSamples = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("n0_cycle1_fin", 64'({finished, busy}), 64'd0);
    @(negedge clk);
    chk("n0_cycle2_fin", 64'({finished, converged}), 64'b10);
    @(negedge clk);
    chk("n0_fin_pulse", 64'(finished), 64'd0);
    chk("n0_no_memrd", 64'(memrd_cnt - m0), 64'd0);
    chk("n0_no_ready", 64'(dr_cnt - d0), 64'd0);

    for (int i = 0; i < 7; i++)
      run_case(vecs[i].n, vecs[i].f, vecs[i].dly, vecs[i].exp_p, vecs[i].exp_c, vecs[i].exp_e);

    for (int i = 0; i < 20; i++) begin
      int n, f, dly, ep, pl;
      bit cv;
      n = $urandom_range(1, 8);
      f = $urandom_range(0, 40);
      dly = $urandom_range(0, 3);
      model(n, f, pl, cv, ep);
      run_case(n, f, dly, pl, cv, ep);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
